completion_buffer: RTL and testbench
====================================

COMPLETION_BUFFER -- requirements
Module: completion_buffer

Interface
REQ-001 The block SHALL have parameter NUM_CB_ENTRY, default 16, giving the number of buffer entries (power of two, 2..64).
REQ-002 The block SHALL have parameter IDX_W, default $clog2(NUM_CB_ENTRY), giving the entry index width.
REQ-003 Port: CLK  input  1  single clock; all state updates on rising edge.
REQ-004 Port: nRST  input  1  reset, asynchronous, active-low.
REQ-005 Port: flush  input  1  discard all entries.
REQ-006 Port: alloc_en  input  1  dispatch requests one entry.
REQ-007 Port: alloc_index  output  IDX_W  index of the entry granted by alloc_en (current tail).
REQ-008 Port: full / empty  output  1 each  occupancy == NUM_CB_ENTRY / occupancy == 0.
REQ-009 Ports: ready_a, ready_mu, ready_du, ready_ls  input  1 each  writeback valid from arith, mult, div, load/store units.
REQ-010 Ports: index_a, index_mu, index_du, index_ls  input  IDX_W each  target entry of each writeback.
REQ-011 Ports: wdata_a, wdata_mu, wdata_du, wdata_ls  input  32 each  result data.
REQ-012 Ports: wen_a/mu/du/ls  input  1 each; reg_rd_a/mu/du/ls  input  5 each  register-write enable and destination.
REQ-013 Port: commit_valid  output  1  head entry retires this cycle.
REQ-014 Ports: commit_wen  output 1; commit_rd  output 5; commit_wdata  output 32; commit_index  output IDX_W  retired entry contents.

Function
REQ-015 Each entry SHALL hold valid, done, wen, rd[4:0], data[31:0]; head, tail (IDX_W bits, wrap modulo NUM_CB_ENTRY) and count (IDX_W+1 bits) SHALL be registered.
REQ-016 alloc_index SHALL equal tail combinationally at all times.
REQ-017 alloc_en with full==0 SHALL set entry[tail].valid=1, done=0 and increment tail and count; alloc_en with full==1 SHALL be ignored (no state change), even if a commit occurs the same cycle.
REQ-018 A writeback (ready_x=1) to an entry with valid=1, done=0 SHALL set done=1 and latch wdata_x, wen_x, reg_rd_x at the clock edge.
REQ-019 A writeback to an entry with valid=0 or done=1 SHALL be ignored.
REQ-020 Multiple writebacks to the same index in one cycle SHALL resolve with priority a > mu > du > ls; lower-priority ones are dropped; writebacks to distinct indices SHALL all complete the same cycle.
REQ-021 commit_valid SHALL be combinational: entry[head].valid && entry[head].done && !flush; commit_wen/rd/wdata/index SHALL reflect entry[head]; at most one commit per cycle.
REQ-022 On commit_valid=1 the entry SHALL be cleared (valid=0, done=0), head incremented, count decremented.
REQ-023 Simultaneous accepted alloc and commit SHALL leave count unchanged.
REQ-024 A writeback to the head entry SHALL become committable no earlier than the next cycle (one-cycle writeback-to-commit latency).
REQ-025 flush=1 SHALL clear every valid/done bit and set head=tail=count=0 at the edge, overriding any same-cycle alloc_en or writeback.
REQ-026 Index wrap-around from NUM_CB_ENTRY-1 to 0 SHALL be seamless for head and tail; full/empty SHALL derive from count only.

Reset
REQ-027 nRST low SHALL asynchronously clear all entries, head, tail, count; outputs after reset: alloc_index=0, full=0, empty=1, commit_valid=0, commit_wen=0, commit_rd=0, commit_wdata=0, commit_index=0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight entries; first alloc after release receives index 0.

Verification
REQ-029 Reset, alloc 3 entries (idx 0,1,2), ready_a idx1 data 0x11, ready_mu idx0 data 0x22 same cycle -> next cycle commit idx0 data 0x22, following cycle idx1 data 0x11, idx2 held, empty=0.
REQ-030 Alloc 16 consecutive cycles -> full=1 after 16th; 17th alloc_en ignored, alloc_index stays 0; one commit with alloc_en same cycle -> alloc still refused, count=15 after edge.
REQ-031 Run 40 alloc/writeback/commit cycles with random out-of-order completion -> commits strictly in allocation order across index wrap 15->0, no loss or duplication.
REQ-032 ready_a and ready_ls both target idx 4 (0xAAAA vs 0xBBBB) -> entry 4 commits 0xAAAA; later ready_du to idx 4 after commit (valid=0) -> ignored.
REQ-033 Flush with 5 entries, one done, plus alloc_en same cycle -> commit_valid=0 that cycle, next cycle empty=1, alloc_index=0.
REQ-034 Drop nRST asynchronously mid-cycle with 7 entries -> outputs at reset values immediately, before next CLK edge.

Source files
------------

// File: rtl/completion_buffer_if.sv
// Completion buffer bus bundle: dispatch allocation, four writeback ports
// (arith, mult, div, load/store) and the in-order commit port.
//   master : the surrounding pipeline (drives alloc/writeback/flush)
//   slave  : the completion buffer itself
interface completion_buffer_if #(
  parameter int IDX_W = 4
);
  logic             flush;
  logic             alloc_en;
  logic [IDX_W-1:0] alloc_index;
  logic             full;
  logic             empty;

  logic             ready_a,  ready_mu,  ready_du,  ready_ls;
  logic [IDX_W-1:0] index_a,  index_mu,  index_du,  index_ls;
  logic [31:0]      wdata_a,  wdata_mu,  wdata_du,  wdata_ls;
  logic             wen_a,    wen_mu,    wen_du,    wen_ls;
  logic [4:0]       reg_rd_a, reg_rd_mu, reg_rd_du, reg_rd_ls;

  logic             commit_valid;
  logic             commit_wen;
  logic [4:0]       commit_rd;
  logic [31:0]      commit_wdata;
  logic [IDX_W-1:0] commit_index;

  modport master (
    output flush, alloc_en,
    output ready_a, ready_mu, ready_du, ready_ls,
    output index_a, index_mu, index_du, index_ls,
    output wdata_a, wdata_mu, wdata_du, wdata_ls,
    output wen_a, wen_mu, wen_du, wen_ls,
    output reg_rd_a, reg_rd_mu, reg_rd_du, reg_rd_ls,
    input  alloc_index, full, empty,
    input  commit_valid, commit_wen, commit_rd, commit_wdata, commit_index
  );

  modport slave (
    input  flush, alloc_en,
    input  ready_a, ready_mu, ready_du, ready_ls,
    input  index_a, index_mu, index_du, index_ls,
    input  wdata_a, wdata_mu, wdata_du, wdata_ls,
    input  wen_a, wen_mu, wen_du, wen_ls,
    input  reg_rd_a, reg_rd_mu, reg_rd_du, reg_rd_ls,
    output alloc_index, full, empty,
    output commit_valid, commit_wen, commit_rd, commit_wdata, commit_index
  );
endinterface

// File: rtl/completion_buffer.sv
// Completion buffer: circular queue of NUM_CB_ENTRY entries. Dispatch
// allocates at the tail, execution units complete entries out of order,
// and the head entry retires in allocation order once it is done.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   cb   - completion_buffer_if.slave (alloc, writeback, flush, commit)
module completion_buffer #(
  parameter int NUM_CB_ENTRY = 16,
  parameter int IDX_W        = $clog2(NUM_CB_ENTRY)
) (
  input logic                CLK,
  input logic                nRST,
  completion_buffer_if.slave cb
);
  localparam int N = NUM_CB_ENTRY;

  logic [N-1:0]     valid_q, valid_d;
  logic [N-1:0]     done_q,  done_d;
  logic [N-1:0]     wen_q,   wen_d;
  logic [4:0]       rd_q   [N];
  logic [4:0]       rd_d   [N];
  logic [31:0]      data_q [N];
  logic [31:0]      data_d [N];
  logic [IDX_W-1:0] head_q,  head_d;
  logic [IDX_W-1:0] tail_q,  tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic             full_w;
  logic             alloc_ok;
  logic             commit_ok;

  // Writeback ports flattened; slot 0 has highest priority.
  logic [3:0]       wb_rdy;
  logic [3:0]       wb_wen;
  logic [IDX_W-1:0] wb_idx  [4];
  logic [31:0]      wb_data [4];
  logic [4:0]       wb_rd   [4];

  assign wb_rdy     = {cb.ready_ls, cb.ready_du, cb.ready_mu, cb.ready_a};
  assign wb_wen     = {cb.wen_ls,   cb.wen_du,   cb.wen_mu,   cb.wen_a};
  assign wb_idx[0]  = cb.index_a;
  assign wb_idx[1]  = cb.index_mu;
  assign wb_idx[2]  = cb.index_du;
  assign wb_idx[3]  = cb.index_ls;
  assign wb_data[0] = cb.wdata_a;
  assign wb_data[1] = cb.wdata_mu;
  assign wb_data[2] = cb.wdata_du;
  assign wb_data[3] = cb.wdata_ls;
  assign wb_rd[0]   = cb.reg_rd_a;
  assign wb_rd[1]   = cb.reg_rd_mu;
  assign wb_rd[2]   = cb.reg_rd_du;
  assign wb_rd[3]   = cb.reg_rd_ls;

  assign full_w    = (count_q == (IDX_W+1)'(N));
  assign alloc_ok  = cb.alloc_en && !full_w;
  assign commit_ok = valid_q[head_q] && done_q[head_q] && !cb.flush;

  assign cb.alloc_index  = tail_q;
  assign cb.full         = full_w;
  assign cb.empty        = (count_q == '0);
  assign cb.commit_valid = commit_ok;
  assign cb.commit_wen   = wen_q[head_q];
  assign cb.commit_rd    = rd_q[head_q];
  assign cb.commit_wdata = data_q[head_q];
  assign cb.commit_index = head_q;

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    wen_d   = wen_q;
    for (int i = 0; i < N; i++) begin
      rd_d[i]   = rd_q[i];
      data_d[i] = data_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (cb.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Walk lowest priority first so a higher-priority unit hitting the
      // same entry overwrites it. Done entries can't also be the freshly
      // allocated tail or the retiring head, so these updates never collide.
      for (int e = 0; e < N; e++) begin
        for (int u = 3; u >= 0; u--) begin
          if (wb_rdy[u] && (wb_idx[u] == IDX_W'(e)) && valid_q[e] && !done_q[e]) begin
            done_d[e] = 1'b1;
            wen_d[e]  = wb_wen[u];
            rd_d[e]   = wb_rd[u];
            data_d[e] = wb_data[u];
          end
        end
      end

      if (commit_ok) begin
        valid_d[head_q] = 1'b0;
        done_d[head_q]  = 1'b0;
        head_d          = head_q + 1'b1;
      end

      if (alloc_ok) begin
        valid_d[tail_q] = 1'b1;
        done_d[tail_q]  = 1'b0;
        tail_d          = tail_q + 1'b1;
      end

      case ({alloc_ok, commit_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      done_q  <= '0;
      wen_q   <= '0;
      for (int i = 0; i < N; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q  <= done_d;
      wen_q   <= wen_d;
      for (int i = 0; i < N; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_completion_buffer.sv
// Self-checking bench for completion_buffer (16 entries). A directed vector
// table covers out-of-order completion, priority and ignored writebacks;
// hand-written sequences cover async reset, full, flush, and a randomized
// in-order retirement run against a small queue model.
module tb_completion_buffer;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  completion_buffer_if #(.IDX_W(4)) cb_if ();

  completion_buffer #(.NUM_CB_ENTRY(16), .IDX_W(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .cb   (cb_if)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        alloc;
    logic        flush;
    logic [3:0]  rdy;            // {ls, du, mu, a}
    logic [3:0]  ia, im, id, il;
    logic [31:0] da, dm, dd, dl;
    logic [3:0]  e_aidx;
    logic        e_full, e_empty, e_cv;
    logic [3:0]  e_cidx;
    logic [31:0] e_cdata;
    logic [4:0]  e_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(int alloc, int flush, int rdy,
                              int ia, int da, int im, int dm,
                              int id, int dd, int il, int dl,
                              int aidx, int full, int empty, int cv,
                              int cidx, int cdata, int rd);
    vec_t v;
    v.alloc = 1'(alloc);  v.flush = 1'(flush);  v.rdy = 4'(rdy);
    v.ia = 4'(ia);  v.im = 4'(im);  v.id = 4'(id);  v.il = 4'(il);
    v.da = 32'(da); v.dm = 32'(dm); v.dd = 32'(dd); v.dl = 32'(dl);
    v.e_aidx = 4'(aidx); v.e_full = 1'(full); v.e_empty = 1'(empty);
    v.e_cv = 1'(cv); v.e_cidx = 4'(cidx); v.e_cdata = 32'(cdata);
    v.e_rd = 5'(rd);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    cb_if.alloc_en = 1'b0;  cb_if.flush    = 1'b0;
    cb_if.ready_a  = 1'b0;  cb_if.ready_mu = 1'b0;
    cb_if.ready_du = 1'b0;  cb_if.ready_ls = 1'b0;
    cb_if.index_a  = '0;    cb_if.index_mu = '0;
    cb_if.index_du = '0;    cb_if.index_ls = '0;
    cb_if.wdata_a  = '0;    cb_if.wdata_mu = '0;
    cb_if.wdata_du = '0;    cb_if.wdata_ls = '0;
  endtask

  task automatic set_wb(input int u, input logic [3:0] idx, input logic [31:0] d);
    case (u)
      0: begin cb_if.ready_a  = 1'b1; cb_if.index_a  = idx; cb_if.wdata_a  = d; end
      1: begin cb_if.ready_mu = 1'b1; cb_if.index_mu = idx; cb_if.wdata_mu = d; end
      2: begin cb_if.ready_du = 1'b1; cb_if.index_du = idx; cb_if.wdata_du = d; end
      default: begin cb_if.ready_ls = 1'b1; cb_if.index_ls = idx; cb_if.wdata_ls = d; end
    endcase
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " alloc_index"},  32'(cb_if.alloc_index),  32'd0);
    chk({tag, " full"},         32'(cb_if.full),         32'd0);
    chk({tag, " empty"},        32'(cb_if.empty),        32'd1);
    chk({tag, " commit_valid"}, 32'(cb_if.commit_valid), 32'd0);
    chk({tag, " commit_wen"},   32'(cb_if.commit_wen),   32'd0);
    chk({tag, " commit_rd"},    32'(cb_if.commit_rd),    32'd0);
    chk({tag, " commit_wdata"}, cb_if.commit_wdata,      32'd0);
    chk({tag, " commit_index"}, 32'(cb_if.commit_index), 32'd0);
  endtask

  // Reference model for the randomized run.
  logic [3:0]  tail_m;
  int          q_m[$];
  logic        done_m [16];
  logic [31:0] data_m [16];
  logic [4:0]  rd_m   [16];
  logic        wen_m  [16];

  task automatic rand_cycle(input bit allow_alloc, input int cyc);
    bit          do_alloc;
    bit          exp_cv;
    int          pend[$];
    bit          wb_v [2];
    int          wb_u [2];
    int          wb_i [2];
    logic [31:0] wb_d [2];
    int          k;
    idle();
    do_alloc = allow_alloc && (q_m.size() < 16) && ($urandom_range(7, 0) != 0);
    foreach (q_m[j]) if (!done_m[q_m[j]]) pend.push_back(q_m[j]);
    for (int s = 0; s < 2; s++) begin
      wb_v[s] = 1'b0;
      if (pend.size() > 0 && $urandom_range(3, 0) != 0) begin
        k       = $urandom_range(pend.size() - 1, 0);
        wb_i[s] = pend[k];
        pend.delete(k);
        wb_u[s] = s * 2 + int'($urandom_range(1, 0));
        wb_d[s] = $urandom;
        wb_v[s] = 1'b1;
        set_wb(wb_u[s], 4'(wb_i[s]), wb_d[s]);
      end
    end
    cb_if.alloc_en = do_alloc;
    exp_cv = (q_m.size() > 0) && done_m[q_m[0]];
    #1;
    chk($sformatf("rnd%0d alloc_index", cyc), 32'(cb_if.alloc_index), 32'(tail_m));
    chk($sformatf("rnd%0d commit_valid", cyc), 32'(cb_if.commit_valid), 32'(exp_cv));
    if (exp_cv) begin
      chk($sformatf("rnd%0d commit_index", cyc), 32'(cb_if.commit_index), 32'(q_m[0]));
      chk($sformatf("rnd%0d commit_wdata", cyc), cb_if.commit_wdata, data_m[q_m[0]]);
      chk($sformatf("rnd%0d commit_rd", cyc), 32'(cb_if.commit_rd), 32'(rd_m[q_m[0]]));
      chk($sformatf("rnd%0d commit_wen", cyc), 32'(cb_if.commit_wen), 32'(wen_m[q_m[0]]));
    end
    tick();
    if (exp_cv) begin
      done_m[q_m[0]] = 1'b0;
      void'(q_m.pop_front());
    end
    for (int s = 0; s < 2; s++) begin
      if (wb_v[s]) begin
        done_m[wb_i[s]] = 1'b1;
        data_m[wb_i[s]] = wb_d[s];
        rd_m[wb_i[s]]   = 5'(wb_u[s] + 1);
        wen_m[wb_i[s]]  = (wb_u[s] != 3);
      end
    end
    if (do_alloc) begin
      q_m.push_back(int'(tail_m));
      done_m[tail_m] = 1'b0;
      tail_m = tail_m + 4'd1;
    end
  endtask

  initial begin
    idle();
    // Per-unit destination/enable; ls carries wen=0 to exercise commit_wen.
    cb_if.wen_a  = 1'b1; cb_if.reg_rd_a  = 5'd1;
    cb_if.wen_mu = 1'b1; cb_if.reg_rd_mu = 5'd2;
    cb_if.wen_du = 1'b1; cb_if.reg_rd_du = 5'd3;
    cb_if.wen_ls = 1'b0; cb_if.reg_rd_ls = 5'd4;

    //            al fl rdy  ia da       im dm     id dd        il dl       aidx fu em cv cidx cdata   rd
    vecs.push_back(mk(1, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       0, 0, 1, 0, 0, 0,      0));
    vecs.push_back(mk(1, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       1, 0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(1, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       2, 0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(0, 0, 4'b0011, 1, 'h11,    0, 'h22,  0, 0,        0, 0,       3, 0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       3, 0, 0, 1, 0, 'h22,   2));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       3, 0, 0, 1, 1, 'h11,   1));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       3, 0, 0, 0, 2, 0,      0));
    vecs.push_back(mk(1, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       3, 0, 0, 0, 2, 0,      0));
    vecs.push_back(mk(1, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       4, 0, 0, 0, 2, 0,      0));
    vecs.push_back(mk(0, 0, 4'b1111, 4, 'hAAAA,  3, 'h44,  2, 'h33,     4, 'hBBBB,  5, 0, 0, 0, 2, 0,      0));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       5, 0, 0, 1, 2, 'h33,   3));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       5, 0, 0, 1, 3, 'h44,   2));
    vecs.push_back(mk(0, 0, 4'b0100, 0, 0,       0, 0,     4, 'hDEAD,   0, 0,       5, 0, 0, 1, 4, 'hAAAA, 1));
    vecs.push_back(mk(0, 0, 4'b0100, 0, 0,       0, 0,     4, 'hCCCC,   0, 0,       5, 0, 1, 0, 5, 0,      0));
    vecs.push_back(mk(1, 0, 4'b1000, 0, 0,       0, 0,     0, 0,        5, 'h77,    5, 0, 1, 0, 5, 0,      0));
    vecs.push_back(mk(0, 0, 4'b1000, 0, 0,       0, 0,     0, 0,        5, 'h55,    6, 0, 0, 0, 5, 0,      0));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       6, 0, 0, 1, 5, 'h55,   4));
    vecs.push_back(mk(0, 0, 4'b0000, 0, 0,       0, 0,     0, 0,        0, 0,       6, 0, 1, 0, 6, 0,      0));

    // Reset state.
    tick();
    chk_reset_outputs("reset");
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Directed vector table.
    foreach (vecs[n]) begin
      idle();
      cb_if.alloc_en = vecs[n].alloc;
      cb_if.flush    = vecs[n].flush;
      if (vecs[n].rdy[0]) set_wb(0, vecs[n].ia, vecs[n].da);
      if (vecs[n].rdy[1]) set_wb(1, vecs[n].im, vecs[n].dm);
      if (vecs[n].rdy[2]) set_wb(2, vecs[n].id, vecs[n].dd);
      if (vecs[n].rdy[3]) set_wb(3, vecs[n].il, vecs[n].dl);
      #1;
      chk($sformatf("v%0d alloc_index", n),  32'(cb_if.alloc_index),  32'(vecs[n].e_aidx));
      chk($sformatf("v%0d full", n),         32'(cb_if.full),         32'(vecs[n].e_full));
      chk($sformatf("v%0d empty", n),        32'(cb_if.empty),        32'(vecs[n].e_empty));
      chk($sformatf("v%0d commit_valid", n), 32'(cb_if.commit_valid), 32'(vecs[n].e_cv));
      chk($sformatf("v%0d commit_index", n), 32'(cb_if.commit_index), 32'(vecs[n].e_cidx));
      if (vecs[n].e_cv) begin
        chk($sformatf("v%0d commit_wdata", n), cb_if.commit_wdata, vecs[n].e_cdata);
        chk($sformatf("v%0d commit_rd", n),    32'(cb_if.commit_rd), 32'(vecs[n].e_rd));
        chk($sformatf("v%0d commit_wen", n),   32'(cb_if.commit_wen), 32'(vecs[n].e_rd != 5'd4));
      end
      tick();
    end

    // Async reset mid-cycle with 7 entries in flight (head 6, tail 6 -> 13).
    idle();
    cb_if.alloc_en = 1'b1;
    repeat (7) tick();
    idle();
    set_wb(0, 4'd6, 32'h99);
    tick();
    idle();
    #1;
    chk("pre_rst commit_valid", 32'(cb_if.commit_valid), 32'd1);
    chk("pre_rst alloc_index",  32'(cb_if.alloc_index),  32'd13);
    #1;
    nRST = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    cb_if.alloc_en = 1'b1;
    #1;
    chk("post_rst alloc_index", 32'(cb_if.alloc_index), 32'd0);
    tick();
    idle();
    #1;
    chk("post_rst alloc_index2", 32'(cb_if.alloc_index), 32'd1);
    chk("post_rst empty",        32'(cb_if.empty),       32'd0);

    // Fill to full from index 0, then overflow and alloc-during-commit.
    cb_if.flush = 1'b1;
    tick();
    idle();
    #1;
    chk("fill0 empty",       32'(cb_if.empty),       32'd1);
    chk("fill0 alloc_index", 32'(cb_if.alloc_index), 32'd0);
    for (int i = 0; i < 16; i++) begin
      cb_if.alloc_en = 1'b1;
      #1;
      chk($sformatf("fill%0d alloc_index", i), 32'(cb_if.alloc_index), 32'(i));
      chk($sformatf("fill%0d full", i),        32'(cb_if.full),        32'd0);
      tick();
    end
    chk("full after 16",        32'(cb_if.full),        32'd1);
    chk("full alloc_index",     32'(cb_if.alloc_index), 32'd0);
    tick();                                       // 17th alloc_en, refused
    chk("overflow full",        32'(cb_if.full),        32'd1);
    chk("overflow alloc_index", 32'(cb_if.alloc_index), 32'd0);
    idle();
    set_wb(0, 4'd0, 32'h1234);
    tick();
    idle();
    cb_if.alloc_en = 1'b1;
    #1;
    chk("full+commit commit_valid", 32'(cb_if.commit_valid), 32'd1);
    chk("full+commit commit_wdata", cb_if.commit_wdata,      32'h1234);
    tick();
    cb_if.alloc_en = 1'b0;
    #1;
    chk("count15 full",        32'(cb_if.full),        32'd0);
    chk("count15 alloc_index", 32'(cb_if.alloc_index), 32'd0);
    cb_if.alloc_en = 1'b1;
    tick();
    idle();
    #1;
    chk("refill full",        32'(cb_if.full),        32'd1);
    chk("refill alloc_index", 32'(cb_if.alloc_index), 32'd1);

    // Flush with 5 entries (head done) plus same-cycle alloc.
    cb_if.flush = 1'b1;
    tick();
    idle();
    cb_if.alloc_en = 1'b1;
    repeat (5) tick();
    idle();
    set_wb(0, 4'd0, 32'h5);
    tick();
    idle();
    cb_if.flush    = 1'b1;
    cb_if.alloc_en = 1'b1;
    #1;
    chk("flush commit_valid", 32'(cb_if.commit_valid), 32'd0);
    tick();
    idle();
    #1;
    chk("flush empty",        32'(cb_if.empty),        32'd1);
    chk("flush alloc_index",  32'(cb_if.alloc_index),  32'd0);
    chk("flush commit_valid2", 32'(cb_if.commit_valid), 32'd0);
    cb_if.alloc_en = 1'b1;
    tick();
    idle();
    #1;
    chk("post_flush commit_valid", 32'(cb_if.commit_valid), 32'd0);
    chk("post_flush alloc_index",  32'(cb_if.alloc_index),  32'd1);
    cb_if.flush = 1'b1;
    tick();
    idle();

    // Randomized out-of-order completion, in-order retirement, with wrap.
    tail_m = 4'd0;
    for (int i = 0; i < 16; i++) done_m[i] = 1'b0;
    for (int c = 0; c < 40; c++) rand_cycle(1'b1, c);
    for (int c = 40; c < 120 && q_m.size() > 0; c++) rand_cycle(1'b0, c);
    idle();
    #1;
    chk("drain empty", 32'(cb_if.empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
